climate_controller: RTL and testbench
=====================================

CLIMATE_CONTROLLER -- requirements
Module: climate_controller

Interface
REQ-001 Parameter COLD_ON, default 8'd15: heating entry threshold; sample < COLD_ON qualifies.
REQ-002 Parameter COLD_OFF, default 8'd20: heating exit threshold; sample >= COLD_OFF exits.
REQ-003 Parameter HOT_ON, default 8'd35: cooling entry threshold; sample > HOT_ON qualifies.
REQ-004 Parameter HOT_OFF, default 8'd30: cooling exit threshold; sample < HOT_OFF exits.
REQ-005 Parameter ALARM_TH, default 8'd60: over-temperature threshold; sample >= ALARM_TH trips the alarm.
REQ-006 Parameter DWELL, default 4: consecutive qualifying samples needed to enter HEATING or COOLING; legal range 1..15.
REQ-007 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-008 Port rst_n  input  1  asynchronous, active-low reset.
REQ-009 Port temp_valid  input  1  qualifies temperature for one cycle; ignored while rst_n is low.
REQ-010 Port temperature  input  8  unsigned sample from the temperature calculator stage, range 0..255.
REQ-011 Port heater_on  output  1  high exactly while state is HEATING.
REQ-012 Port cooler_on  output  1  high while state is COOLING or ALARM.
REQ-013 Port fan_speed  output  2  fan level 0..3.
REQ-014 Port state  output  2  NORMAL=00, HEATING=01, COOLING=10, ALARM=11.
REQ-015 Port alarm  output  1  high exactly while state is ALARM.
REQ-016 Port temp_last  output  8  last accepted sample.

Function
REQ-017 All outputs are registered; every update occurs on the clk edge where temp_valid=1 and is visible the following cycle (1-cycle latency).
REQ-018 Cycles with temp_valid=0 leave state, counters, temp_last and outputs unchanged.
REQ-019 temp_last loads temperature on every accepted sample.
REQ-020 The alarm rule has highest priority: from any state, a sample >= ALARM_TH moves to ALARM and clears the dwell counter.
REQ-021 From ALARM, a sample < HOT_OFF moves to NORMAL; any other sample keeps ALARM.
REQ-022 In NORMAL, a 4-bit dwell counter tracks consecutive samples on one side:
- increments on each cold (< COLD_ON) or hot (> HOT_ON) sample;
- restarts at 1 when the side changes;
- clears on a sample in COLD_ON..HOT_ON.
REQ-023 In NORMAL, when the counter value including the current sample reaches DWELL, the block moves to HEATING (cold side) or COOLING (hot side) and clears the counter; DWELL=1 therefore enters on the first qualifying sample.
REQ-024 In HEATING, a sample >= COLD_OFF moves to NORMAL; otherwise HEATING holds.
REQ-025 In COOLING, a sample < HOT_OFF moves to NORMAL; otherwise COOLING holds.
REQ-026 The counter saturates at 15, is cleared on every state change, and is held outside NORMAL.
REQ-027 fan_speed is computed from the post-update state and the sample:
- NORMAL and HEATING: 0;
- COOLING: 1 if sample < 45, 2 if sample < 55, else 3;
- ALARM: 3.
REQ-028 Sample compares are unsigned 8-bit; values 0 and 255 are legal and are handled by the same rules.
REQ-029 A sample that falls inside a hysteresis band (COLD_ON..COLD_OFF-1 or HOT_OFF..HOT_ON) never changes HEATING or COOLING.

Reset
REQ-030 While rst_n=0, asynchronously and independent of clk: state=NORMAL, counter=0, temp_last=0, heater_on=0, cooler_on=0, fan_speed=0, alarm=0.
REQ-031 Reset asserted mid-dwell or in any state aborts the operation; after release the first accepted sample is treated as the first sample of a new sequence.
REQ-032 Release of rst_n takes effect at the next clk edge; no sample is accepted on the release edge if temp_valid=0.

Verification
REQ-033 Samples 10,10,10 -> state stays NORMAL; 4th sample 10 -> state=01, heater_on=1 one cycle later.
REQ-034 In HEATING, sample 18 -> HEATING held; sample 20 -> state=00, heater_on=0.
REQ-035 Samples 40,40,25,40,40,40,40 -> counter cleared by 25; COOLING entered only after the last 40, with fan_speed=1; a following sample 50 -> fan_speed=2.
REQ-036 From NORMAL with counter=2, sample 60 -> state=11, alarm=1, cooler_on=1, fan_speed=3; sample 45 -> ALARM held; sample 29 -> state=00, all outputs 0.
REQ-037 Sample 10,10,10 followed by rst_n pulsed low between clk edges -> outputs 0 immediately; then 10,10,10 -> still NORMAL, fourth 10 -> HEATING.
REQ-038 temp_valid=0 for 20 cycles with temperature toggling between 0 and 255 -> no output or state change.

Source files
------------

// File: rtl/climate_controller.sv
// Hysteretic heat/cool/alarm controller driven by qualified 8-bit temperature samples.
// Outputs are registered and change only on accepted samples.
module climate_controller #(
  parameter logic [7:0] COLD_ON  = 8'd15,
  parameter logic [7:0] COLD_OFF = 8'd20,
  parameter logic [7:0] HOT_ON   = 8'd35,
  parameter logic [7:0] HOT_OFF  = 8'd30,
  parameter logic [7:0] ALARM_TH = 8'd60,
  parameter int         DWELL    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       temp_valid,
  input  logic [7:0] temperature,
  output logic       heater_on,
  output logic       cooler_on,
  output logic [1:0] fan_speed,
  output logic [1:0] state,
  output logic       alarm,
  output logic [7:0] temp_last
);

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'b00,
    ST_HEATING = 2'b01,
    ST_COOLING = 2'b10,
    ST_ALARM   = 2'b11
  } state_t;

  localparam logic [3:0] DWELL_L = 4'(DWELL);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       side_hot_q, side_hot_d;
  logic [3:0] cnt_inc;
  logic [3:0] run_len;
  logic [1:0] fan_d;
  logic       is_cold, is_hot;

  logic       heater_q, cooler_q, alarm_q;
  logic [1:0] fan_q;
  logic [7:0] temp_last_q;

  assign is_cold = (temperature < COLD_ON);
  assign is_hot  = (temperature > HOT_ON);
  assign cnt_inc = (cnt_q == 4'd15) ? 4'd15 : cnt_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    side_hot_d = side_hot_q;
    run_len    = 4'd0;

    if (temperature >= ALARM_TH) begin
      state_d = ST_ALARM;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        ST_NORMAL: begin
          if (is_cold || is_hot) begin
            // A run continues only while samples stay on the same side.
            run_len    = (cnt_q != 4'd0 && side_hot_q == is_hot) ? cnt_inc : 4'd1;
            side_hot_d = is_hot;
            if (run_len >= DWELL_L) begin
              state_d = is_hot ? ST_COOLING : ST_HEATING;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = run_len;
            end
          end else begin
            cnt_d = 4'd0;
          end
        end
        ST_HEATING: begin
          if (temperature >= COLD_OFF) state_d = ST_NORMAL;
          cnt_d = 4'd0;
        end
        ST_COOLING, ST_ALARM: begin
          if (temperature < HOT_OFF) state_d = ST_NORMAL;
          cnt_d = 4'd0;
        end
        default: begin
          state_d = ST_NORMAL;
          cnt_d   = 4'd0;
        end
      endcase
    end

    case (state_d)
      ST_COOLING: begin
        if (temperature < 8'd45)      fan_d = 2'd1;
        else if (temperature < 8'd55) fan_d = 2'd2;
        else                          fan_d = 2'd3;
      end
      ST_ALARM: fan_d = 2'd3;
      default:  fan_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_NORMAL;
      cnt_q       <= 4'd0;
      side_hot_q  <= 1'b0;
      heater_q    <= 1'b0;
      cooler_q    <= 1'b0;
      alarm_q     <= 1'b0;
      fan_q       <= 2'd0;
      temp_last_q <= 8'd0;
    end else if (temp_valid) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      side_hot_q  <= side_hot_d;
      heater_q    <= (state_d == ST_HEATING);
      cooler_q    <= (state_d == ST_COOLING) || (state_d == ST_ALARM);
      alarm_q     <= (state_d == ST_ALARM);
      fan_q       <= fan_d;
      temp_last_q <= temperature;
    end
  end

  assign state     = state_q;
  assign heater_on = heater_q;
  assign cooler_on = cooler_q;
  assign alarm     = alarm_q;
  assign fan_speed = fan_q;
  assign temp_last = temp_last_q;

endmodule

// File: tb/tb_climate_controller.sv
// Directed and random samples checked against a history-based reference model.
module tb_climate_controller;

  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       temp_valid;
  logic [7:0] temperature;
  logic       heater_on, cooler_on, alarm;
  logic [1:0] fan_speed, state;
  logic [7:0] temp_last;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: mode, last sample, and the sides of recent NORMAL samples.
  int m_state = 0;
  int m_last  = 0;
  int hist[$];

  climate_controller #(.DWELL(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .temp_valid(temp_valid), .temperature(temperature),
    .heater_on(heater_on), .cooler_on(cooler_on), .fan_speed(fan_speed),
    .state(state), .alarm(alarm), .temp_last(temp_last)
  );

  always #5 clk = ~clk;

  function automatic int exp_fan();
    if (m_state == 3) return 3;
    if (m_state != 2) return 0;
    if (m_last < 45) return 1;
    if (m_last < 55) return 2;
    return 3;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_last  = 0;
    hist.delete();
  endtask

  task automatic model_apply(input int t);
    bit same;
    m_last = t;
    if (t >= 60) begin
      m_state = 3;
      hist.delete();
    end else begin
      case (m_state)
        0: begin
          if (t < 15)      hist.push_back(-1);
          else if (t > 35) hist.push_back(1);
          else             hist.delete();
          while (hist.size() > DWELL) void'(hist.pop_front());
          if (hist.size() == DWELL) begin
            same = 1'b1;
            foreach (hist[i]) if (hist[i] != hist[0]) same = 1'b0;
            if (same) begin
              m_state = (hist[0] < 0) ? 1 : 2;
              hist.delete();
            end
          end
        end
        1: if (t >= 20) m_state = 0;
        default: if (t < 30) m_state = 0;
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_state"},  {6'd0, state},     8'(m_state));
    chk({tag, "_heater"}, {7'd0, heater_on}, 8'(m_state == 1));
    chk({tag, "_cooler"}, {7'd0, cooler_on}, 8'(m_state >= 2));
    chk({tag, "_alarm"},  {7'd0, alarm},     8'(m_state == 3));
    chk({tag, "_fan"},    {6'd0, fan_speed}, 8'(exp_fan()));
    chk({tag, "_last"},   temp_last,         8'(m_last));
  endtask

  task automatic send(input int t, input string tag);
    @(negedge clk);
    temp_valid  = 1'b1;
    temperature = 8'(t);
    model_apply(t);
    @(posedge clk);
    #1;
    temp_valid = 1'b0;
    check_all(tag);
    $display("sample %0d -> state=%0d heater=%0b cooler=%0b fan=%0d alarm=%0b last=%0d [%s]",
             t, state, heater_on, cooler_on, fan_speed, alarm, temp_last, tag);
  endtask

  task automatic idle(input int t, input string tag);
    @(negedge clk);
    temp_valid  = 1'b0;
    temperature = 8'(t);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    $display("reset pulse -> state=%0d heater=%0b fan=%0d [%s]", state, heater_on, fan_speed, tag);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int t, sel;
    rst_n       = 1'b0;
    temp_valid  = 1'b0;
    temperature = 8'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(0, "release");

    // Heating entry after DWELL cold samples, hysteresis hold, exit.
    for (int i = 0; i < 4; i++) send(10, "heat_entry");
    send(18, "heat_hold");
    send(20, "heat_exit");

    // Neutral sample clears the run; cooling fan levels.
    send(40, "cool_a"); send(40, "cool_b"); send(25, "cool_clear");
    for (int i = 0; i < 4; i++) send(40, "cool_entry");
    send(50, "cool_fan2");
    send(30, "cool_hold");
    send(29, "cool_exit");

    // Alarm from mid-dwell, hold, exit.
    send(40, "alm_pre"); send(40, "alm_pre");
    send(60, "alm_trip");
    send(45, "alm_hold");
    send(30, "alm_hold30");
    send(29, "alm_exit");

    // Reset mid-dwell aborts the sequence.
    for (int i = 0; i < 3; i++) send(10, "rst_pre");
    pulse_reset("rst_mid");
    for (int i = 0; i < 4; i++) send(10, "rst_post");
    send(19, "heat_band");
    send(255, "max_alarm");
    send(0, "min_exit");

    // Side change restarts the run.
    send(14, "side"); send(14, "side"); send(36, "side_chg");
    send(36, "side"); send(36, "side"); send(36, "side_cool");
    send(56, "fan3"); send(35, "band_hot"); send(0, "cool_to_norm");
    for (int i = 0; i < 4; i++) send(15, "edge15");

    // Invalid cycles leave everything unchanged.
    for (int i = 0; i < 20; i++) idle((i % 2) ? 255 : 0, "idle");

    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       t = $urandom_range(0, 22);
        1:       t = $urandom_range(26, 40);
        2:       t = $urandom_range(28, 70);
        default: t = $urandom_range(0, 255);
      endcase
      if ($urandom_range(0, 4) == 0) idle(t, "rnd_idle");
      else if ($urandom_range(0, 60) == 0) pulse_reset("rnd_reset");
      else send(t, "rnd");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
